// File: rtl/detector_jogada.sv
// Button conditioner for the memory game: synchronises, debounces and validates presses.
// Ports: clock/reset(n), botoes raw in; jogada code, jogada_pulso, tem_jogada, invalida, db_estado out.
module detector_jogada #(
  parameter int NUM_BOTOES      = 4,
  parameter int DEBOUNCE_CYCLES = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic [NUM_BOTOES-1:0] jogada,
  output logic                  jogada_pulso,
  output logic                  tem_jogada,
  output logic                  invalida,
  output logic [2:0]            db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    FILTRANDO   = 3'd1,
    ACEITA      = 3'd2,
    PRESSIONADO = 3'd3,
    SOLTANDO    = 3'd4,
    INVALIDA    = 3'd5,
    BLOQUEADO   = 3'd6
  } estado_t;

  logic [NUM_BOTOES-1:0] sync1_q;
  logic [NUM_BOTOES-1:0] sync2_q;
  logic [NUM_BOTOES-1:0] cand_q;
  logic [NUM_BOTOES-1:0] jogada_q;
  logic [CW-1:0]         cnt_q;
  logic                  valido_q;
  logic                  pulso_q;
  logic                  inval_q;
  estado_t               estado_q;

  logic [NUM_BOTOES-1:0] s;
  logic                  s_zero;
  logic                  cand_onehot;

  assign s      = sync2_q;
  assign s_zero = (s == '0);

  // one-hot: nonzero with no second bit set
  assign cand_onehot = (cand_q != '0) &&
                       ((cand_q & (cand_q - 1'b1)) == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      jogada_q <= '0;
      cnt_q    <= '0;
      valido_q <= 1'b0;
      pulso_q  <= 1'b0;
      inval_q  <= 1'b0;
      estado_q <= OCIOSO;
    end else begin
      sync1_q <= botoes;
      sync2_q <= sync1_q;
      pulso_q <= 1'b0;
      inval_q <= 1'b0;
      unique case (estado_q)
        OCIOSO: begin
          if (!s_zero) begin
            estado_q <= FILTRANDO;
            cand_q   <= s;
            cnt_q    <= CNT_ONE;
          end
        end
        FILTRANDO: begin
          if (s_zero) begin
            estado_q <= OCIOSO;
          end else if (s != cand_q) begin
            cand_q <= s;
            cnt_q  <= CNT_ONE;
          end else if (cnt_q < CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (cand_onehot) begin
            // strobe and code land together with the ACEITA state
            estado_q <= ACEITA;
            jogada_q <= cand_q;
            valido_q <= 1'b1;
            pulso_q  <= 1'b1;
          end else begin
            estado_q <= INVALIDA;
            valido_q <= 1'b0;
            inval_q  <= 1'b1;
          end
        end
        ACEITA: begin
          estado_q <= PRESSIONADO;
        end
        INVALIDA: begin
          estado_q <= BLOQUEADO;
        end
        PRESSIONADO, BLOQUEADO: begin
          if (s_zero) begin
            estado_q <= SOLTANDO;
            cnt_q    <= CNT_ONE;
          end
        end
        SOLTANDO: begin
          // release bounce returns to the held state, never re-fires
          if (!s_zero) begin
            estado_q <= valido_q ? PRESSIONADO : BLOQUEADO;
          end else if (cnt_q < CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            estado_q <= OCIOSO;
          end
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign jogada       = jogada_q;
  assign jogada_pulso = pulso_q;
  assign invalida     = inval_q;
  assign db_estado    = estado_q;
  assign tem_jogada   = valido_q &&
                        ((estado_q == ACEITA) ||
                         (estado_q == PRESSIONADO) ||
                         (estado_q == SOLTANDO));

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed spec scenarios plus random presses
// checked every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_detector_jogada;

  localparam int D = 5;

  logic       clock;
  logic       reset;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       jogada_pulso;
  logic       tem_jogada;
  logic       invalida;
  logic [2:0] db_estado;

  detector_jogada #(.NUM_BOTOES(4), .DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .jogada       (jogada),
    .jogada_pulso (jogada_pulso),
    .tem_jogada   (tem_jogada),
    .invalida     (invalida),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: two-sample delay line, then run lengths of
  // identical samples decide accept / reject / release
  logic [3:0] p1, p2;
  bit         m_held, m_ack, m_valid, m_pulse, m_inval;
  logic [3:0] m_val, m_jog;
  int         m_run, m_zrun;

  // scenario observation counters
  int n_pulse, n_inval, n_tem, t_idx, first_pulse;
  logic [3:0] got_codes[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n == 1;
  endfunction

  task model_reset();
    p1 = '0; p2 = '0;
    m_held = 0; m_ack = 0; m_valid = 0;
    m_pulse = 0; m_inval = 0;
    m_val = '0; m_jog = '0;
    m_run = 0; m_zrun = 0;
  endtask

  task model_step(input logic [3:0] s);
    m_pulse = 0;
    m_inval = 0;
    if (!m_held) begin
      if (s == 0) m_run = 0;
      else if (m_run == 0 || s != m_val) begin
        m_val = s;
        m_run = 1;
      end else begin
        m_run++;
        if (m_run == D + 1) begin
          m_held = 1; m_ack = 1; m_zrun = 0; m_run = 0;
          if (is_onehot(m_val)) begin
            m_valid = 1; m_jog = m_val; m_pulse = 1;
          end else begin
            m_valid = 0; m_inval = 1;
          end
        end
      end
    end else if (m_ack) begin
      m_ack = 0;
    end else if (s == 0) begin
      m_zrun++;
      if (m_zrun == D + 1) begin
        m_held = 0; m_run = 0;
      end
    end else begin
      m_zrun = 0;
    end
  endtask

  function automatic logic [2:0] model_code();
    if (!m_held) return (m_run == 0) ? 3'd0 : 3'd1;
    if (m_ack) return m_valid ? 3'd2 : 3'd5;
    if (m_zrun == 0) return m_valid ? 3'd3 : 3'd6;
    return 3'd4;
  endfunction

  task check_outputs();
    chk("jogada", 32'(jogada), 32'(m_jog));
    chk("jogada_pulso", 32'(jogada_pulso), 32'(m_pulse));
    chk("tem_jogada", 32'(tem_jogada), 32'(m_held && m_valid));
    chk("invalida", 32'(invalida), 32'(m_inval));
    chk("db_estado", 32'(db_estado), 32'(model_code()));
  endtask

  task tick(input logic [3:0] b);
    botoes = b;
    @(posedge clock);
    if (!reset) model_reset();
    else begin
      model_step(p2);
      p2 = p1;
      p1 = b;
    end
    #1;
    cyc++;
    if (jogada_pulso === 1'b1) begin
      if (n_pulse == 0) first_pulse = t_idx;
      n_pulse++;
      got_codes.push_back(jogada);
    end
    if (invalida === 1'b1) n_inval++;
    if (tem_jogada === 1'b1) n_tem++;
    t_idx++;
    check_outputs();
  endtask

  task clr();
    n_pulse = 0; n_inval = 0; n_tem = 0;
    t_idx = 0; first_pulse = -1;
    got_codes.delete();
  endtask

  task hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  logic [3:0] exp_codes[$];
  logic [3:0] code;

  initial begin
    reset = 1'b1;
    botoes = '0;
    model_reset();
    clr();
    #2 reset = 1'b0;

    // 1: reset, idle inputs
    hold(4'b0000, 2);
    reset = 1'b1;
    hold(4'b0000, 10);
    chk("s1_db_idle", 32'(db_estado), 32'd0);

    // 2: single valid press
    clr();
    hold(4'b0100, 10);
    hold(4'b0000, 10);
    chk("s2_pulses", n_pulse, 1);
    chk("s2_latency", first_pulse, D + 2);
    chk("s2_code", 32'(jogada), 32'h4);
    chk("s2_db_idle", 32'(db_estado), 32'd0);

    // 3: short glitch
    clr();
    hold(4'b0010, 3);
    hold(4'b0000, 8);
    chk("s3_pulses", n_pulse, 0);
    chk("s3_inval", n_inval, 0);
    chk("s3_code", 32'(jogada), 32'h4);
    chk("s3_db_idle", 32'(db_estado), 32'd0);

    // 4: two buttons at once
    clr();
    hold(4'b0011, 10);
    chk("s4_inval", n_inval, 1);
    chk("s4_pulses", n_pulse, 0);
    chk("s4_tem", n_tem, 0);
    chk("s4_code", 32'(jogada), 32'h4);
    hold(4'b0000, 10);

    // 5: release bounce
    clr();
    hold(4'b1000, 10);
    tick(4'b0000);
    tick(4'b1000);
    tick(4'b0000);
    hold(4'b0000, 10);
    chk("s5_pulses", n_pulse, 1);
    chk("s5_code", 32'(jogada), 32'h8);

    // 6: reset while pressed, button still held
    hold(4'b0001, 10);
    chk("s6_pressed", 32'(db_estado), 32'd3);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    hold(4'b0001, 2);
    reset = 1'b1;
    clr();
    hold(4'b0001, 10);
    chk("s6_repress", n_pulse, 1);
    chk("s6_latency", first_pulse, D + 2);
    hold(4'b0000, 10);

    // game replay
    clr();
    exp_codes.delete();
    for (int i = 0; i < 16; i++) begin
      code = 4'b0001 << (i % 4);
      exp_codes.push_back(code);
      hold(code, 10);
      hold(4'b0000, 10);
    end
    chk("game_count", n_pulse, 16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_codes.size())
        chk($sformatf("game_code%0d", i), 32'(got_codes[i]),
            32'(exp_codes[i]));
    end

    // random presses, glitches and bounces
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(1, 15));
      else code = 4'b0001 << $urandom_range(0, 3);
      hold(code, $urandom_range(1, 12));
      if ($urandom_range(0, 2) == 0) begin
        tick(4'b0000);
        tick(code);
      end
      hold(4'b0000, $urandom_range(1, 10));
    end
    hold(4'b0000, 10);
    chk("rand_db_idle", 32'(db_estado), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
